// File: rtl/fp_pkg.sv
// Shared definitions for the fixed-point multiply/align stages.
package fp_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Default Qi.f formats for operand a, operand b and result c
  localparam int I1 = 2;
  localparam int F1 = 14;
  localparam int I2 = 2;
  localparam int F2 = 14;
  localparam int I3 = 2;
  localparam int F3 = 14;

  localparam int W1 = I1 + F1;
  localparam int W2 = I2 + F2;
  localparam int W3 = I3 + F3;
  localparam int PW = W1 + W2;
  localparam int PF = F1 + F2;

  // Width of the saturation-limit comparison; aligned magnitudes must fit
  localparam int LIMW = 64;

  // Largest magnitude representable in a w-bit result.
  // Signed: 2^(w-1)-1 positive, 2^(w-1) negative. Unsigned: 2^w-1.
  function automatic logic [LIMW-1:0] q_limit(input int w, input logic sgn,
                                               input logic neg);
    logic [LIMW-1:0] one;
    one = 1;
    if (!sgn)      return (one << w) - one;
    else if (neg)  return one << (w - 1);
    else           return (one << (w - 1)) - one;
  endfunction

endpackage

// File: rtl/fp_align_sat.sv
// Aligns an unsigned full-precision magnitude to the output Q format,
// saturates it against the signed/unsigned range and applies the sign.
module fp_align_sat
  import fp_pkg::*;
#(
  parameter int MW = PW,   // magnitude width
  parameter int MF = PF,   // magnitude fraction bits
  parameter int WC = W3,   // result width
  parameter int FC = F3    // result fraction bits
) (
  input  logic [MW-1:0] mag,
  input  logic          neg,
  input  logic          sign,
  output logic [WC-1:0] c,
  output logic          overflow,
  output logic          underflow
);

  localparam int SH = (MF > FC) ? MF - FC : 0;
  localparam int LS = (FC > MF) ? FC - MF : 0;
  localparam int AW = MW + LS;

  logic [AW-1:0]   aligned;
  logic [WC-1:0]   low;
  logic [LIMW-1:0] limit;
  logic            neg_nz;

  // Truncation toward zero drops low bits; a left shift loses nothing
  generate
    if (MF > FC) begin : g_trunc
      assign aligned   = mag >> SH;
      assign underflow = |mag[SH-1:0];
    end else begin : g_ext
      assign aligned   = AW'(mag) << LS;
      assign underflow = 1'b0;
    end
  endgenerate

  // Range check and sign application; a zero magnitude is never negative
  always_comb begin
    neg_nz   = neg && (aligned != '0);
    limit    = q_limit(WC, sign, neg_nz);
    overflow = LIMW'(aligned) > limit;
    low      = WC'(aligned);
    if (overflow) begin
      if (!sign)      c = '1;
      else if (neg_nz) c = {1'b1, {(WC-1){1'b0}}};
      else            c = {1'b0, {(WC-1){1'b1}}};
    end else begin
      c = neg_nz ? -low : low;
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Radix-2 shift-add fixed-point multiplier, one bit of |b| per cycle,
// with valid/ready on both sides and a saturating aligned result.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int i1 = I1,
  parameter int f1 = F1,
  parameter int i2 = I2,
  parameter int f2 = F2,
  parameter int i3 = I3,
  parameter int f3 = F3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [i1+f1-1:0] a,
  input  logic             s1,
  input  logic [i2+f2-1:0] b,
  input  logic             s2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [i3+f3-1:0] c,
  output logic             sign,
  output logic             overflow,
  output logic             underflow
);

  localparam int WA = i1 + f1;
  localparam int WB = i2 + f2;
  localparam int WC = i3 + f3;
  localparam int WP = WA + WB;
  localparam int FP = f1 + f2;
  localparam int CW = (WB > 1) ? $clog2(WB) : 1;

  state_t          state, state_nx;
  logic [WP-1:0]   a_sh, acc, acc_nx;
  logic [WB-1:0]   b_sh;
  logic [CW-1:0]   cnt;
  logic            neg_r, sign_r, last;
  logic            a_neg, b_neg;
  logic [WA-1:0]   a_mag;
  logic [WB-1:0]   b_mag;
  logic [WC-1:0]   c_nx;
  logic            ovf_nx, unf_nx;

  // Operand magnitudes; the most-negative value maps to 2^(W-1), still W bits
  assign a_neg  = s1 && a[WA-1];
  assign b_neg  = s2 && b[WB-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign last   = (cnt == CW'(WB - 1));
  assign acc_nx = b_sh[0] ? acc + a_sh : acc;

  // Final partial sum goes straight into alignment so DONE has the result
  fp_align_sat #(.MW(WP), .MF(FP), .WC(WC), .FC(f3)) u_align (
    .mag       (acc_nx),
    .neg       (neg_r),
    .sign      (sign_r),
    .c         (c_nx),
    .overflow  (ovf_nx),
    .underflow (unf_nx)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = CALC;
      CALC:    if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture on accept, shift-add in CALC, register result on exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_r     <= 1'b0;
      sign_r    <= 1'b0;
      c         <= '0;
      sign      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh   <= WP'(a_mag);
          b_sh   <= b_mag;
          acc    <= '0;
          cnt    <= '0;
          neg_r  <= a_neg ^ b_neg;
          sign_r <= s1 | s2;
        end
        CALC: begin
          acc  <= acc_nx;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (last) begin
            c         <= c_nx;
            sign      <= sign_r;
            overflow  <= ovf_nx;
            underflow <= unf_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
Sequential radix-2 shift-add fixed-point multiplier that produces operands for the fp_add adder stage. It uses the same Qi.f operand convention and per-operand signed flags. The full-precision product is aligned to the output format, saturated, and flagged. A valid/ready handshake on both sides lets it sit directly ahead of the adder in a multiply-accumulate datapath.

Parameters:
i1, 2, integer bits of operand a
f1, 14, fraction bits of operand a
i2, 2, integer bits of operand b; W2=i2+f2 also sets the iteration count
f2, 14, fraction bits of operand b
i3, 2, integer bits of result c
f3, 14, fraction bits of result c

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operands a/b/s1/s2 are valid
in_ready  output  1  block can accept operands
a  input  i1+f1  operand a
s1  input  1  1 = a is two's complement, 0 = a is unsigned
b  input  i2+f2  operand b
s2  input  1  1 = b is two's complement, 0 = b is unsigned
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts the result
c  output  i3+f3  result, two's complement if sign=1, else unsigned
sign  output  1  s1||s2 of the accepted transaction
overflow  output  1  result was saturated
underflow  output  1  nonzero fraction bits were discarded

Behaviour:
- Reset values (async, immediate): state IDLE; in_ready=1; out_valid=0; c=0; sign=0; overflow=0; underflow=0; internal registers cleared.
- FSM state IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture operands; go to CALC.
  - Each operand is converted to magnitude when its s-flag=1 and its MSB=1.
  - Product sign neg = (a negative) XOR (b negative); sign = s1||s2.
  - Most-negative input, e.g. 0x8000, has magnitude 2^(W-1); it must fit unsigned in W bits and is not an error.
- FSM state CALC:
  - in_ready=0.
  - One bit of |b| per cycle, LSB first: if the bit is set, add |a| shifted by the counter to the accumulator.
  - Accumulator width is W1+W2 with f1+f2 fraction bits.
  - Counter runs 0..W2-1; after the last bit, go to DONE.
- Exit from CALC to DONE, same edge:
  - Alignment: if f1+f2>f3, truncate the magnitude right by (f1+f2-f3), rounding toward zero. underflow=1 iff any discarded bit is 1. If f1+f2<=f3, shift left and underflow=0.
  - Signed result (sign=1) limits: positive max 2^(W3-1)-1, negative max magnitude 2^(W3-1).
  - Unsigned result (sign=0) limit: max 2^W3-1.
  - Saturation: if the magnitude exceeds its limit, overflow=1 and c saturates to 0x7F..F (positive), 0x80..0 (negative), or all-ones (unsigned). Otherwise c = neg ? -mag : mag.
  - A zero product is never negative: c=0 even if neg=1.
- FSM state DONE:
  - out_valid=1; c, sign, overflow and underflow held stable until out_ready=1.
  - On out_valid&&out_ready: out_valid=0 next cycle, go to IDLE; c and flags hold their last values.
- Latency: accept edge at cycle T, out_valid high from cycle T+W2+1 (17 at defaults). Throughput is one result per W2+2 cycles when out_ready is held high.
- in_valid is ignored outside IDLE; no operand is lost, because in_ready=0 there.
- A reset asserted in CALC or DONE aborts the transaction with no output; the block returns to the reset values.

Decomposition:
- Shared package fp_pkg:
  - state enum (IDLE, CALC, DONE);
  - helper function for the Q-format saturation limit;
  - localparams W1, W2, W3, PW=W1+W2, PF=f1+f2.
- One natural sub-module, fp_align_sat: combinational alignment, saturation and negation from {mag, neg, sign} to {c, overflow, underflow}, reusable by other fixed-point stages.

Test Plan:
- a=0x6000, s1=0, b=0x5000, s2=0 (1.5*1.25) -> c=0x7800, sign=0, overflow=0, underflow=0; out_valid exactly 17 cycles after accept.
- a=0xA000, s1=1, b=0x5000, s2=0 (-1.5*1.25) -> c=0x8800 (-1.875), sign=1, overflow=0.
- Overflow, unsigned: a=0xC000, b=0x8000, s1=s2=0 (3.0*2.0) -> c=0xFFFF, overflow=1. Overflow, signed: a=0x8000, b=0x8000, s1=s2=1 (-2*-2) -> c=0x7FFF, overflow=1.
- a=0x0001, b=0x0001 unsigned -> c=0x0000, underflow=1, overflow=0. a=0x4000, b=0x0000 -> c=0, both flags 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> c and flags stable, in_ready=0, a new in_valid is not accepted. Release -> in_ready=1 the next cycle.
- Assert rst at cycle 8 of CALC -> outputs go to reset values immediately and no out_valid occurs. A new transaction after reset yields the correct product.
